vga_timing_ctrl: RTL
====================

Name: vga_timing_ctrl

Overview:
- Raster sequencer for the 800x600@60 SVGA display path on a 40 MHz pixel clock.
- Owns the horizontal pixel counter and advances a vertical line counter on each horizontal wrap.
- Runs horizontal and vertical phase FSMs and drives registered hsync, vsync, display-enable, pixel coordinates and line/frame strobes to the pixel generator and the VGA pins.

Parameters:
- H_ACTIVE, 800, visible pixels per line
- H_FRONT, 40, horizontal front porch (pixels)
- H_SYNC, 128, hsync pulse width (pixels)
- H_BACK, 88, horizontal back porch (pixels); H total = 1056
- V_ACTIVE, 600, visible lines per frame
- V_FRONT, 1, vertical front porch (lines)
- V_SYNC, 4, vsync pulse width (lines)
- V_BACK, 23, vertical back porch (lines); V total = 628
- H_SYNC_POL, 1, hsync active level
- V_SYNC_POL, 1, vsync active level

Ports:
- clk  in  1  pixel clock, 40 MHz
- rst  in  1  synchronous reset, active-high
- en  in  1  advance enable; low freezes the raster
- x  out  11  registered pixel column, 0..1055
- y  out  10  registered line, 0..627
- de  out  1  display enable: x<800 and y<600
- hsync  out  1  horizontal sync at H_SYNC_POL
- vsync  out  1  vertical sync at V_SYNC_POL
- line_start  out  1  one-cycle strobe with x==0
- frame_start  out  1  one-cycle strobe with x==0, y==0
- hphase  out  2  horizontal FSM state
- vphase  out  2  vertical FSM state

Behaviour:
- Clock and reset: single clock domain. rst is synchronous and active-high, sampled on the rising edge of clk, and takes priority over en.
- Reset values:
  - internal h=0, v=0
  - outputs: x=0, y=0, de=0, line_start=0, frame_start=0
  - hsync=~H_SYNC_POL, vsync=~V_SYNC_POL
  - hphase=vphase=ACTIVE
- Pipeline: outputs are a registered decode of the internal counters, so they lag the counters by 1 cycle. The first enabled edge after reset presents x=0, y=0, de=1, line_start=1, frame_start=1.
- Counters, on each edge with en=1:
  - h increments. At h==1055, h wraps to 0 and v increments.
  - At h==1055 and v==627, both wrap to 0 on the same edge.
  - No intermediate values are skipped or repeated.
- en=0: counters, FSM states and every output hold their value. Strobes also hold, so downstream logic qualifies strobes with en.
- Horizontal FSM, phase encoding ACTIVE=0, FRONT=1, SYNC=2, BACK=3:
  - ACTIVE for h 0..799
  - FRONT for h 800..839
  - SYNC for h 840..967
  - BACK for h 968..1055
  - Transitions occur on threshold compare of the incremented h.
  - BACK->ACTIVE occurs on wrap.
- Vertical FSM, same encoding:
  - ACTIVE for v 0..599
  - FRONT for v 600
  - SYNC for v 601..604
  - BACK for v 605..627
  - Vertical transitions occur only on edges where h wraps.
- Sync outputs:
  - hsync = H_SYNC_POL exactly while hphase==SYNC, i.e. 128 cycles per line.
  - vsync = V_SYNC_POL exactly while vphase==SYNC, i.e. 4 full lines (4224 cycles), aligned to the x==0 boundary.
- Display enable: de = (hphase==ACTIVE && vphase==ACTIVE). No de pulse in blanking.
- Widths: h is 11 bits and v is 10 bits. Totals are derived from the parameters; widths must hold total-1. Compares use unsigned arithmetic.
- Reset mid-frame: the next edge returns the block to the reset state. The first enabled edge after rst deasserts restarts the raster at (0,0) with frame_start=1. No partial sync pulse persists.

Optional Feature:
- Macro: VGA_FRAME_COUNT_EN.
- Defined:
  - Adds output port frame_count (8 bits), reset to 0.
  - Increments on the same edge that presents frame_start=1; the first frame after reset reads 1.
  - Wraps 255->0 and holds when en=0.
- Undefined: port and logic are absent. All other behaviour is identical.

Test Plan:
- Reset, then en=1 for 1 cycle -> before the edge all outputs hold reset values with hsync=0, vsync=0; after the edge x=0, y=0, de=1, line_start=1, frame_start=1.
- en=1, run 1056 cycles on line 0 -> de high for exactly 800 cycles (x 0..799). hsync high x 840..967 (128 cycles). Then x wraps 1055->0, y=1, line_start=1, frame_start=0.
- Run a full frame of 663168 cycles -> vsync high exactly over lines 601..604 (4224 cycles). vphase sequence 0,1,2,3. At x=1055, y=627 the next presented pixel is x=0, y=0, frame_start=1.
- en toggled low for 10 cycles at x=500, y=10 -> x, y, de and hphase are frozen for those 10 cycles. Resuming en presents x=501 with no skip.
- rst asserted for 1 cycle at x=900, y=602 (hsync and vsync active) -> next edge gives reset values. Next enabled edge gives x=0, y=0, frame_start=1.
- With VGA_FRAME_COUNT_EN, run 256 frames -> frame_count steps 1..255 then 0, changing only on frame_start edges.

Source files
------------

// File: rtl/vga_timing_ctrl.sv
// Raster sequencer for 800x600@60: h/v counters, phase FSMs and registered sync/de/strobe outputs.
// Optional VGA_FRAME_COUNT_EN adds an 8-bit frame_count output.
module vga_timing_ctrl #(
    parameter int   H_ACTIVE   = 800,
    parameter int   H_FRONT    = 40,
    parameter int   H_SYNC     = 128,
    parameter int   H_BACK     = 88,
    parameter int   V_ACTIVE   = 600,
    parameter int   V_FRONT    = 1,
    parameter int   V_SYNC     = 4,
    parameter int   V_BACK     = 23,
    parameter logic H_SYNC_POL = 1'b1,
    parameter logic V_SYNC_POL = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [10:0] x,
    output logic [9:0]  y,
    output logic        de,
    output logic        hsync,
    output logic        vsync,
    output logic        line_start,
    output logic        frame_start,
    output logic [1:0]  hphase,
    output logic [1:0]  vphase
`ifdef VGA_FRAME_COUNT_EN
    ,
    output logic [7:0]  frame_count
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_FP_START = 11'(H_ACTIVE);
    localparam logic [10:0] H_SY_START = 11'(H_ACTIVE + H_FRONT);
    localparam logic [10:0] H_BP_START = 11'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_FP_START = 10'(V_ACTIVE);
    localparam logic [9:0]  V_SY_START = 10'(V_ACTIVE + V_FRONT);
    localparam logic [9:0]  V_BP_START = 10'(V_ACTIVE + V_FRONT + V_SYNC);

    typedef enum logic [1:0] {
        PH_ACTIVE = 2'd0,
        PH_FRONT  = 2'd1,
        PH_SYNC   = 2'd2,
        PH_BACK   = 2'd3
    } phase_e;

    logic [10:0] h_q, h_d, h_inc, x_q, x_d;
    logic [9:0]  v_q, v_d, v_inc, y_q, y_d;
    phase_e      hst_q, hst_d, vst_q, vst_d;
    logic        de_q, de_d, hsync_q, hsync_d, vsync_q, vsync_d;
    logic        ls_q, ls_d, fs_q, fs_d;
    logic [1:0]  hph_q, hph_d, vph_q, vph_d;
`ifdef VGA_FRAME_COUNT_EN
    logic [7:0]  fc_q, fc_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            h_q     <= '0;
            v_q     <= '0;
            hst_q   <= PH_ACTIVE;
            vst_q   <= PH_ACTIVE;
            x_q     <= '0;
            y_q     <= '0;
            de_q    <= 1'b0;
            hsync_q <= ~H_SYNC_POL;
            vsync_q <= ~V_SYNC_POL;
            ls_q    <= 1'b0;
            fs_q    <= 1'b0;
            hph_q   <= PH_ACTIVE;
            vph_q   <= PH_ACTIVE;
`ifdef VGA_FRAME_COUNT_EN
            fc_q    <= '0;
`endif
        end else begin
            h_q     <= h_d;
            v_q     <= v_d;
            hst_q   <= hst_d;
            vst_q   <= vst_d;
            x_q     <= x_d;
            y_q     <= y_d;
            de_q    <= de_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            ls_q    <= ls_d;
            fs_q    <= fs_d;
            hph_q   <= hph_d;
            vph_q   <= vph_d;
`ifdef VGA_FRAME_COUNT_EN
            fc_q    <= fc_d;
`endif
        end
    end

    always_comb begin
        h_d     = h_q;
        v_d     = v_q;
        hst_d   = hst_q;
        vst_d   = vst_q;
        x_d     = x_q;
        y_d     = y_q;
        de_d    = de_q;
        hsync_d = hsync_q;
        vsync_d = vsync_q;
        ls_d    = ls_q;
        fs_d    = fs_q;
        hph_d   = hph_q;
        vph_d   = vph_q;
        h_inc   = h_q + 11'd1;
        v_inc   = v_q + 10'd1;
`ifdef VGA_FRAME_COUNT_EN
        fc_d    = fc_q;
`endif
        if (en) begin
            // Outputs present the counter/phase values from before this edge's advance.
            x_d     = h_q;
            y_d     = v_q;
            hph_d   = hst_q;
            vph_d   = vst_q;
            de_d    = (hst_q == PH_ACTIVE) && (vst_q == PH_ACTIVE);
            hsync_d = (hst_q == PH_SYNC) ? H_SYNC_POL : ~H_SYNC_POL;
            vsync_d = (vst_q == PH_SYNC) ? V_SYNC_POL : ~V_SYNC_POL;
            ls_d    = (h_q == '0);
            fs_d    = (h_q == '0) && (v_q == '0);
`ifdef VGA_FRAME_COUNT_EN
            if ((h_q == '0) && (v_q == '0))
                fc_d = fc_q + 8'd1;
`endif
            if (h_q == H_LAST) begin
                h_d   = '0;
                hst_d = PH_ACTIVE;
                if (v_q == V_LAST) begin
                    v_d   = '0;
                    vst_d = PH_ACTIVE;
                end else begin
                    v_d = v_inc;
                    if (v_inc == V_FP_START)
                        vst_d = PH_FRONT;
                    else if (v_inc == V_SY_START)
                        vst_d = PH_SYNC;
                    else if (v_inc == V_BP_START)
                        vst_d = PH_BACK;
                end
            end else begin
                h_d = h_inc;
                if (h_inc == H_FP_START)
                    hst_d = PH_FRONT;
                else if (h_inc == H_SY_START)
                    hst_d = PH_SYNC;
                else if (h_inc == H_BP_START)
                    hst_d = PH_BACK;
            end
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign de          = de_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign line_start  = ls_q;
    assign frame_start = fs_q;
    assign hphase      = hph_q;
    assign vphase      = vph_q;
`ifdef VGA_FRAME_COUNT_EN
    assign frame_count = fc_q;
`endif

endmodule
